dmem_responder: RTL



---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/dmem_ram.sv | 23 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types, defaults and address decode for the data-memory responder
package mips_mem_pkg;

    typedef enum logic [1:0] {
        VERDICT_RUN     = 2'd0,
        VERDICT_PASS    = 2'd1,
        VERDICT_FAIL    = 2'd2,
        VERDICT_TIMEOUT = 2'd3
    } verdict_e;

    localparam int unsigned DEF_PASS_ADDR    = 84;
    localparam int unsigned DEF_PASS_DATA    = 7;
    localparam int unsigned DEF_SCRATCH_ADDR = 80;
    localparam int unsigned DEF_TIMEOUT      = 1000;

    typedef struct packed {
        logic in_range;
        logic aligned;
    } addr_dec_t;

    // Limit is computed in 33 bits so a DEPTH of 2^30 words still compares correctly.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr, input int unsigned depth);
        addr_dec_t   dec;
        logic [32:0] limit;
        limit        = 33'(depth) << 2;
        dec.in_range = ({1'b0, addr} < limit);
        dec.aligned  = (addr[1:0] == 2'b00);
        return dec;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - DEPTHx32 word RAM, synchronous write, combinational read
module dmem_ram #(
    parameter int unsigned DEPTH     = 64,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-port memory with store-driven pass/fail/timeout verdict
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter logic [31:0] PASS_ADDR    = 32'(DEF_PASS_ADDR),
    parameter logic [31:0] PASS_DATA    = 32'(DEF_PASS_DATA),
    parameter logic [31:0] SCRATCH_ADDR = 32'(DEF_SCRATCH_ADDR),
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] write_count,
    output logic [31:0] last_addr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = $clog2(TIMEOUT + 1);

    addr_dec_t   dec;
    logic        addr_ok;
    logic        ram_we;
    logic [31:0] ram_rdata;

    assign dec     = decode_addr(dataaddr, DEPTH);
    assign addr_ok = dec.in_range & dec.aligned;
    assign ram_we  = memwrite & ~reset & addr_ok;

    dmem_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (dataaddr[AW+1:2]),
        .wdata (writedata),
        .rdata (ram_rdata)
    );

    assign readdata = dec.in_range ? ram_rdata : 32'h0;

    verdict_e       state_q, state_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [15:0]    count_q, count_d;
    logic [31:0]    last_q, last_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           fail_q, fail_d;
    logic           timeout_q, timeout_d;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        count_d = count_q;
        last_d  = last_q;

        if (memwrite) begin
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
            last_d = dataaddr;
        end

        // A deciding store outranks the watchdog expiring on the same edge.
        if (state_q == VERDICT_RUN) begin
            wd_d = wd_q + WDW'(1);
            if (memwrite && (dataaddr == PASS_ADDR)) begin
                state_d = (writedata == PASS_DATA) ? VERDICT_PASS : VERDICT_FAIL;
            end else if (memwrite && !addr_ok && (dataaddr != SCRATCH_ADDR)) begin
                // The scratch word is always safe to store to, even if placed outside the RAM.
                state_d = VERDICT_FAIL;
            end else if (wd_d == WDW'(TIMEOUT)) begin
                state_d = VERDICT_TIMEOUT;
            end
        end

        done_d    = (state_d != VERDICT_RUN);
        pass_d    = (state_d == VERDICT_PASS);
        fail_d    = (state_d == VERDICT_FAIL);
        timeout_d = (state_d == VERDICT_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= VERDICT_RUN;
            wd_q      <= '0;
            count_q   <= '0;
            last_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            count_q   <= count_d;
            last_q    <= last_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign write_count = count_q;
    assign last_addr   = last_q;

endmodule
